// File: rtl/alu_rs_pkg.sv
// Shared constants for the ALU reservation station: opcode encodings, tag widths,
// default sizes, the per-entry payload type and the CDB snoop helper.
package alu_rs_pkg;

  localparam int TYPE_BIT      = 4;
  localparam int ROB_INDEX_BIT = 4;
  localparam int RS_SIZE_DEF   = 8;
  localparam int AGE_BIT_DEF   = 4;

  typedef enum logic [TYPE_BIT-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SLT = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic [TYPE_BIT-1:0]      op;
    logic [31:0]              vj;
    logic [31:0]              vk;
    logic [ROB_INDEX_BIT-1:0] qj;
    logic [ROB_INDEX_BIT-1:0] qk;
    logic                     j_rdy;
    logic                     k_rdy;
    logic [ROB_INDEX_BIT-1:0] rob_id;
  } rs_entry_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] val;
  } opnd_t;

  // A not-ready operand picks up its value from whichever CDB carries its tag;
  // ALU broadcast wins if both match (they never should).
  function automatic opnd_t cdb_snoop(
    input logic                     rdy,
    input logic [ROB_INDEX_BIT-1:0] tag,
    input logic [31:0]              val,
    input logic                     alu_v,
    input logic [ROB_INDEX_BIT-1:0] alu_id,
    input logic [31:0]              alu_val,
    input logic                     lsb_v,
    input logic [ROB_INDEX_BIT-1:0] lsb_id,
    input logic [31:0]              lsb_val
  );
    opnd_t res;
    res.rdy = rdy;
    res.val = val;
    if (!rdy && alu_v && (alu_id == tag)) begin
      res.rdy = 1'b1;
      res.val = alu_val;
    end else if (!rdy && lsb_v && (lsb_id == tag)) begin
      res.rdy = 1'b1;
      res.val = lsb_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Dispatch picker: one-hot grant among eligible entries.
// RS_OLDEST_FIRST_EN selects the oldest (ties to lowest index); otherwise lowest index.
module rs_select
  import alu_rs_pkg::*;
#(
  parameter int N       = RS_SIZE_DEF,
  parameter int AGE_BIT = AGE_BIT_DEF
) (
  input  logic [N-1:0]         i_eligible,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [N*AGE_BIT-1:0] i_ages,
`endif
  output logic [N-1:0]         o_grant,
  output logic                 o_valid
);

  assign o_valid = |i_eligible;

`ifdef RS_OLDEST_FIRST_EN
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0]   w_best_idx;
  logic [AGE_BIT-1:0] w_best_age;
  logic               w_found;

  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    w_best_idx = '0;
    w_best_age = '0;
    w_found    = 1'b0;
    o_grant    = '0;
    for (int i = 0; i < N; i++) begin
      if (i_eligible[i] && (!w_found || (i_ages[i*AGE_BIT +: AGE_BIT] > w_best_age))) begin
        w_found    = 1'b1;
        w_best_age = i_ages[i*AGE_BIT +: AGE_BIT];
        w_best_idx = IDX_W'(i);
      end
    end
    if (w_found) o_grant[w_best_idx] = 1'b1;
  end
`else
  assign o_grant = i_eligible & (-i_eligible);
`endif

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: issue into lowest free slot, CDB wakeup, one dispatch per cycle.
// Optional macro RS_OLDEST_FIRST_EN adds per-entry age counters and oldest-first dispatch.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int AGE_BIT = AGE_BIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     issue_valid,
  input  logic [TYPE_BIT-1:0]      issue_type,
  input  logic [31:0]              issue_vj,
  input  logic [31:0]              issue_vk,
  input  logic [ROB_INDEX_BIT-1:0] issue_qj,
  input  logic [ROB_INDEX_BIT-1:0] issue_qk,
  input  logic                     issue_j_rdy,
  input  logic                     issue_k_rdy,
  input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
  output logic                     full,
  output logic                     alu_req,
  output logic [TYPE_BIT-1:0]      alu_type,
  output logic [31:0]              alu_r1,
  output logic [31:0]              alu_r2,
  output logic [ROB_INDEX_BIT-1:0] alu_rob_id,
  input  logic                     cdb_alu_valid,
  input  logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id,
  input  logic [31:0]              cdb_alu_value,
  input  logic                     cdb_lsb_valid,
  input  logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id,
  input  logic [31:0]              cdb_lsb_value
);

  // Issue handshake: an issue is taken at a clock edge when issue_valid=1, full=0,
  // rdy_in=1 and clear_in=0; the producer must not rely on anything else.
  logic [RS_SIZE-1:0] r_busy;
  rs_entry_t          r_ent [RS_SIZE];

  logic [RS_SIZE-1:0] w_free_oh;
  logic [RS_SIZE-1:0] w_eligible;
  logic [RS_SIZE-1:0] w_grant;
  logic               w_grant_valid;
  logic               w_issue_ok;
  rs_entry_t          w_new;
  rs_entry_t          w_pick;
  opnd_t              w_new_j;
  opnd_t              w_new_k;
  opnd_t              w_wj [RS_SIZE];
  opnd_t              w_wk [RS_SIZE];

  assign full       = &r_busy;
  assign w_free_oh  = (~r_busy) & (-(~r_busy));
  assign w_issue_ok = issue_valid & ~full & ~clear_in;

  always_comb begin
    w_new_j = cdb_snoop(issue_j_rdy, issue_qj, issue_vj, cdb_alu_valid, cdb_alu_rob_id,
                        cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
    w_new_k = cdb_snoop(issue_k_rdy, issue_qk, issue_vk, cdb_alu_valid, cdb_alu_rob_id,
                        cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
    w_new.op     = issue_type;
    w_new.vj     = w_new_j.val;
    w_new.vk     = w_new_k.val;
    w_new.qj     = issue_qj;
    w_new.qk     = issue_qk;
    w_new.j_rdy  = w_new_j.rdy;
    w_new.k_rdy  = w_new_k.rdy;
    w_new.rob_id = issue_rob_id;
  end

  // Eligibility uses registered flags only, so a same-cycle write or wakeup waits a cycle.
  always_comb begin
    w_pick = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_eligible[i] = r_busy[i] & r_ent[i].j_rdy & r_ent[i].k_rdy;
      w_wj[i] = cdb_snoop(r_ent[i].j_rdy, r_ent[i].qj, r_ent[i].vj, cdb_alu_valid,
                          cdb_alu_rob_id, cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id,
                          cdb_lsb_value);
      w_wk[i] = cdb_snoop(r_ent[i].k_rdy, r_ent[i].qk, r_ent[i].vk, cdb_alu_valid,
                          cdb_alu_rob_id, cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id,
                          cdb_lsb_value);
      if (w_grant[i]) w_pick = r_ent[i];
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  localparam logic [AGE_BIT-1:0] AGE_MAX = '1;

  logic [AGE_BIT-1:0]         r_age [RS_SIZE];
  logic [RS_SIZE*AGE_BIT-1:0] w_ages;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) w_ages[i*AGE_BIT +: AGE_BIT] = r_age[i];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_issue_ok && w_free_oh[i]) r_age[i] <= '0;
        else if (r_busy[i] && (r_age[i] != AGE_MAX)) r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
`endif

  rs_select #(
    .N       (RS_SIZE),
    .AGE_BIT (AGE_BIT)
  ) u_select (
    .i_eligible (w_eligible),
`ifdef RS_OLDEST_FIRST_EN
    .i_ages     (w_ages),
`endif
    .o_grant    (w_grant),
    .o_valid    (w_grant_valid)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy     <= '0;
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      alu_req    <= 1'b0;
      alu_type   <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_busy  <= '0;
        alu_req <= 1'b0;
      end else begin
        alu_req <= w_grant_valid;
        if (w_grant_valid) begin
          alu_type   <= w_pick.op;
          alu_r1     <= w_pick.vj;
          alu_r2     <= w_pick.vk;
          alu_rob_id <= w_pick.rob_id;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_issue_ok && w_free_oh[i]) begin
            r_busy[i] <= 1'b1;
            r_ent[i]  <= w_new;
          end else if (r_busy[i]) begin
            if (w_grant[i]) r_busy[i] <= 1'b0;
            r_ent[i].vj    <= w_wj[i].val;
            r_ent[i].j_rdy <= w_wj[i].rdy;
            r_ent[i].vk    <= w_wk[i].val;
            r_ent[i].k_rdy <= w_wk[i].rdy;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue/dispatch latency, CDB wakeup, full, order, clear, stall, reset.
// Expected dispatch order follows RS_OLDEST_FIRST_EN when it is defined for the build.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     clear_in;
  logic                     issue_valid;
  logic [TYPE_BIT-1:0]      issue_type;
  logic [31:0]              issue_vj, issue_vk;
  logic [ROB_INDEX_BIT-1:0] issue_qj, issue_qk;
  logic                     issue_j_rdy, issue_k_rdy;
  logic [ROB_INDEX_BIT-1:0] issue_rob_id;
  logic                     full;
  logic                     alu_req;
  logic [TYPE_BIT-1:0]      alu_type;
  logic [31:0]              alu_r1, alu_r2;
  logic [ROB_INDEX_BIT-1:0] alu_rob_id;
  logic                     cdb_alu_valid;
  logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id;
  logic [31:0]              cdb_alu_value;
  logic                     cdb_lsb_valid;
  logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id;
  logic [31:0]              cdb_lsb_value;

  int total = 0;
  int bad   = 0;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_vj(issue_vj),
    .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_j_rdy(issue_j_rdy), .issue_k_rdy(issue_k_rdy), .issue_rob_id(issue_rob_id),
    .full(full), .alu_req(alu_req), .alu_type(alu_type), .alu_r1(alu_r1),
    .alu_r2(alu_r2), .alu_rob_id(alu_rob_id),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id),
    .cdb_alu_value(cdb_alu_value), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [3:0] qj, input logic [3:0] qk, input logic jr,
                           input logic kr, input logic [3:0] rob);
    issue_valid = 1'b1; issue_type = op; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qk = qk; issue_j_rdy = jr; issue_k_rdy = kr; issue_rob_id = rob;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0;
  endtask

  task automatic set_cdb_alu(input logic v, input logic [3:0] id, input logic [31:0] val);
    cdb_alu_valid = v; cdb_alu_rob_id = id; cdb_alu_value = val;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; no_issue();
    issue_type = '0; issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    issue_j_rdy = 1'b0; issue_k_rdy = 1'b0; issue_rob_id = '0;
    set_cdb_alu(1'b0, 4'd0, 32'd0);
    cdb_lsb_valid = 1'b0; cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
    #3;
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", alu_req); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if ({alu_type, alu_r1, alu_r2, alu_rob_id} !== '0) begin bad++;
      $display("FAIL reset_outs got=%h/%h/%h/%h exp=0", alu_type, alu_r1, alu_r2, alu_rob_id); end
    @(posedge clk_in); @(negedge clk_in);
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_issue(OP_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3);
    tick();
    no_issue();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b exp=0", alu_req); end
    tick();
    total++; if (alu_req !== 1'b1) begin bad++; $display("FAIL basic_req got=%0b exp=1", alu_req); end
    total++; if (alu_type !== OP_ADD) begin bad++; $display("FAIL basic_type got=%0d exp=%0d", alu_type, OP_ADD); end
    total++; if (alu_r1 !== 32'd5 || alu_r2 !== 32'd7) begin bad++;
      $display("FAIL basic_ops got=%0d,%0d exp=5,7", alu_r1, alu_r2); end
    total++; if (alu_rob_id !== 4'd3) begin bad++; $display("FAIL basic_rob got=%0d exp=3", alu_rob_id); end
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL basic_freed got=%0b exp=0", alu_req); end
  endtask

  task automatic test_wakeup();
    set_issue(OP_SUB, 32'hdead, 32'd3, 4'd4, 4'd0, 1'b0, 1'b1, 4'd5);
    tick();
    no_issue();
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL wake_wait got=%0b exp=0", alu_req); end
    set_cdb_alu(1'b1, 4'd4, 32'h10);
    tick();
    set_cdb_alu(1'b0, 4'd0, 32'd0);
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL wake_same got=%0b exp=0", alu_req); end
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd5) begin bad++;
      $display("FAIL wake_disp got=%0b/%0d exp=1/5", alu_req, alu_rob_id); end
    total++; if (alu_r1 !== 32'h10 || alu_r2 !== 32'd3 || alu_type !== OP_SUB) begin bad++;
      $display("FAIL wake_ops got=%h,%h,%0d exp=10,3,%0d", alu_r1, alu_r2, alu_type, OP_SUB); end
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL wake_freed got=%0b exp=0", alu_req); end
  endtask

  task automatic test_same_cycle();
    set_issue(OP_AND, 32'd2, 32'hbeef, 4'd0, 4'd6, 1'b1, 1'b0, 4'd7);
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 4'd6; cdb_lsb_value = 32'd9;
    tick();
    no_issue(); cdb_lsb_valid = 1'b0;
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd7) begin bad++;
      $display("FAIL same_disp got=%0b/%0d exp=1/7", alu_req, alu_rob_id); end
    total++; if (alu_r1 !== 32'd2 || alu_r2 !== 32'd9) begin bad++;
      $display("FAIL same_ops got=%0d,%0d exp=2,9", alu_r1, alu_r2); end
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL same_freed got=%0b exp=0", alu_req); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_issue(OP_OR, 32'hbad, 32'(i), 4'(8 + i), 4'd0, 1'b0, 1'b1, 4'(i));
      tick();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_set got=%0b exp=1", full); end
    set_issue(OP_OR, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd12);
    tick();
    no_issue();
    total++; if (full !== 1'b1 || alu_req !== 1'b0) begin bad++;
      $display("FAIL full_drop got=%0b/%0b exp=1/0", full, alu_req); end
    set_cdb_alu(1'b1, 4'd8, 32'h55);
    tick();
    set_cdb_alu(1'b0, 4'd0, 32'd0);
    total++; if (alu_req !== 1'b0 || full !== 1'b1) begin bad++;
      $display("FAIL full_wake got=%0b/%0b exp=0/1", alu_req, full); end
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd0 || alu_r1 !== 32'h55) begin bad++;
      $display("FAIL full_disp got=%0b/%0d/%h exp=1/0/55", alu_req, alu_rob_id, alu_r1); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_clr got=%0b exp=0", full); end
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    total++; if (alu_req !== 1'b0 || full !== 1'b0) begin bad++;
      $display("FAIL full_flush got=%0b/%0b exp=0/0", alu_req, full); end
  endtask

  task automatic test_order();
    logic [3:0] first_rob, second_rob;
    logic [31:0] first_r2, second_r2;
`ifdef RS_OLDEST_FIRST_EN
    first_rob = 4'd11; first_r2 = 32'd4; second_rob = 4'd12; second_r2 = 32'd5;
`else
    first_rob = 4'd12; first_r2 = 32'd5; second_rob = 4'd11; second_r2 = 32'd4;
`endif
    set_issue(OP_XOR, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd10);
    tick();
    set_issue(OP_SLT, 32'd0, 32'd4, 4'd2, 4'd0, 1'b0, 1'b1, 4'd11);
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd10) begin bad++;
      $display("FAIL order_d got=%0b/%0d exp=1/10", alu_req, alu_rob_id); end
    set_issue(OP_SLL, 32'd0, 32'd5, 4'd2, 4'd0, 1'b0, 1'b1, 4'd12);
    tick();
    no_issue();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL order_idle got=%0b exp=0", alu_req); end
    set_cdb_alu(1'b1, 4'd2, 32'h77);
    tick();
    set_cdb_alu(1'b0, 4'd0, 32'd0);
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== first_rob || alu_r2 !== first_r2 || alu_r1 !== 32'h77) begin bad++;
      $display("FAIL order_first got=%0b/%0d/%0d/%h exp=1/%0d/%0d/77", alu_req, alu_rob_id, alu_r2, alu_r1, first_rob, first_r2); end
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== second_rob || alu_r2 !== second_r2) begin bad++;
      $display("FAIL order_second got=%0b/%0d/%0d exp=1/%0d/%0d", alu_req, alu_rob_id, alu_r2, second_rob, second_r2); end
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL order_done got=%0b exp=0", alu_req); end
  endtask

  task automatic test_clear();
    for (int k = 1; k <= 3; k++) begin
      set_issue(OP_SUB, 32'd0, 32'd0, 4'd3, 4'd0, 1'b0, 1'b1, 4'(k));
      tick();
    end
    clear_in = 1'b1;
    set_issue(OP_ADD, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
    set_cdb_alu(1'b1, 4'd3, 32'd1);
    tick();
    clear_in = 1'b0; no_issue(); set_cdb_alu(1'b0, 4'd0, 32'd0);
    total++; if (alu_req !== 1'b0 || full !== 1'b0) begin bad++;
      $display("FAIL clear_now got=%0b/%0b exp=0/0", alu_req, full); end
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL clear_issue got=%0b exp=0", alu_req); end
    set_cdb_alu(1'b1, 4'd3, 32'd1);
    tick();
    set_cdb_alu(1'b0, 4'd0, 32'd0);
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL clear_gone got=%0b exp=0", alu_req); end
  endtask

  task automatic test_stall();
    set_issue(OP_ADD, 32'h11, 32'h22, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
    tick();
    set_issue(OP_OR, 32'd0, 32'h44, 4'd5, 4'd0, 1'b0, 1'b1, 4'd4);
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd9) begin bad++;
      $display("FAIL stall_pre got=%0b/%0d exp=1/9", alu_req, alu_rob_id); end
    rdy_in = 1'b0; clear_in = 1'b1;
    set_issue(OP_XOR, 32'd3, 32'd3, 4'd0, 4'd0, 1'b1, 1'b1, 4'd14);
    set_cdb_alu(1'b1, 4'd5, 32'h99);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd9 || alu_r1 !== 32'h11 || alu_r2 !== 32'h22) begin bad++;
        $display("FAIL stall_hold got=%0b/%0d/%h/%h exp=1/9/11/22", alu_req, alu_rob_id, alu_r1, alu_r2); end
    end
    rdy_in = 1'b1; clear_in = 1'b0; no_issue(); set_cdb_alu(1'b0, 4'd0, 32'd0);
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL stall_nocap got=%0b exp=0", alu_req); end
    set_cdb_alu(1'b1, 4'd5, 32'h31);
    tick();
    set_cdb_alu(1'b0, 4'd0, 32'd0);
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd4 || alu_r1 !== 32'h31 || alu_r2 !== 32'h44) begin bad++;
      $display("FAIL stall_after got=%0b/%0d/%h/%h exp=1/4/31/44", alu_req, alu_rob_id, alu_r1, alu_r2); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_issue(OP_ADD, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      if (k <= 3) set_issue(OP_ADD, 32'(k), 32'(k + 1), 4'd0, 4'd0, 1'b1, 1'b1, 4'(k));
      else no_issue();
      tick();
      total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'(k - 1) || alu_r1 !== 32'(k - 1)) begin bad++;
        $display("FAIL b2b_%0d got=%0b/%0d/%0d exp=1/%0d/%0d", k - 1, alu_req, alu_rob_id, alu_r1, k - 1, k - 1); end
    end
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b exp=0", alu_req); end
  endtask

  task automatic test_reset_mid();
    set_issue(OP_AND, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd13);
    tick();
    set_issue(OP_AND, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd14);
    tick();
    no_issue();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd13) begin bad++;
      $display("FAIL rstm_pre got=%0b/%0d exp=1/13", alu_req, alu_rob_id); end
    #2 rst_in = 1'b0;
    #1;
    total++; if (alu_req !== 1'b0 || alu_rob_id !== 4'd0 || alu_r1 !== 32'd0 || alu_type !== 4'd0) begin bad++;
      $display("FAIL rstm_async got=%0b/%0d/%0d/%0d exp=0/0/0/0", alu_req, alu_rob_id, alu_r1, alu_type); end
    tick();
    #2 rst_in = 1'b1;
    tick();
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL rstm_discard got=%0b exp=0", alu_req); end
    set_issue(OP_SRL, 32'd8, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6);
    tick();
    no_issue();
    tick();
    total++; if (alu_req !== 1'b1 || alu_rob_id !== 4'd6 || alu_type !== OP_SRL) begin bad++;
      $display("FAIL rstm_resume got=%0b/%0d/%0d exp=1/6/%0d", alu_req, alu_rob_id, alu_type, OP_SRL); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_same_cycle();
    test_full();
    test_order();
    test_clear();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have parameter AGE_BIT, default 4, width of the per-entry age counter.
REQ-003 SHALL have ports `clk_in`, in, 1, clock; `rst_in`, in, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have ports `rdy_in`, in, 1, stall when low; `clear_in`, in, 1, misprediction flush.
REQ-005 SHALL have ports `issue_valid`, in, 1, and `issue_type`, in, TYPE_BIT, ALU opcode.
REQ-006 SHALL have ports `issue_vj`/`issue_vk`, in, 32, operand values, and `issue_qj`/`issue_qk`, in, ROB_INDEX_BIT, producer tags.
REQ-007 SHALL have ports `issue_j_rdy`/`issue_k_rdy`, in, 1, operand value valid, and `issue_rob_id`, in, ROB_INDEX_BIT, destination.
REQ-008 SHALL have ports `full`, out, 1, no free entry.
REQ-009 SHALL have ports `alu_req`, out, 1; `alu_type`, out, TYPE_BIT; `alu_r1`/`alu_r2`, out, 32; `alu_rob_id`, out, ROB_INDEX_BIT.
REQ-010 SHALL have ports `cdb_alu_valid`, in, 1; `cdb_alu_rob_id`, in, ROB_INDEX_BIT; `cdb_alu_value`, in, 32.
REQ-011 SHALL have ports `cdb_lsb_valid`, in, 1; `cdb_lsb_rob_id`, in, ROB_INDEX_BIT; `cdb_lsb_value`, in, 32.

Function
REQ-012 SHALL have each entry hold: busy, type, vj, vk, qj, qk, j_rdy, k_rdy, rob_id, age.
REQ-013 SHALL drive `full` combinationally high iff all RS_SIZE entries are busy; issue while full is ignored.
REQ-014 SHALL, on an accepted issue, write the lowest-index free entry and set busy at the next edge.
REQ-015 SHALL, for an issuing operand not ready whose tag matches a same-cycle valid CDB broadcast, capture the CDB value and mark the operand ready.
REQ-016 SHALL, for every busy entry each cycle, capture the CDB value and set the ready flag of any not-ready operand whose tag equals a valid broadcast (ALU or LSB).
REQ-017 SHALL treat an entry as eligible for dispatch only when busy, j_rdy and k_rdy are all set in registered state.
REQ-018 SHALL not dispatch an entry that is written or woken in the current cycle before the following cycle.
REQ-019 SHALL, if any entry is eligible, select one per REQ-030, register alu_req=1 with alu_type=type, alu_r1=vj, alu_r2=vk and alu_rob_id=rob_id, and clear that entry's busy at the same edge.
REQ-020 SHALL register alu_req=0 when no entry is eligible; other ALU outputs hold their last value.
REQ-021 SHALL dispatch at most one entry per cycle, with a throughput of 1 per cycle.
REQ-022 SHALL allow issue and dispatch in the same cycle; the slot freed by dispatch is reusable only from the next cycle.
REQ-023 SHALL, on clear_in=1 at an edge with rdy_in=1, clear all busy bits and alu_req; clear has priority over issue, wakeup and dispatch.
REQ-024 SHALL, when rdy_in=0, hold all state and outputs, ignoring issue, CDB and clear.
REQ-025 SHALL zero an entry's age on issue and increment it each cycle the entry is busy, saturating at 2^AGE_BIT-1.

Reset
REQ-026 SHALL, while rst_in=0, asynchronously clear all busy bits, ready flags and ages.
REQ-027 SHALL, while rst_in=0, force alu_req=0, alu_type=0, alu_r1=0, alu_r2=0 and alu_rob_id=0.
REQ-028 SHALL discard any in-progress issue or dispatch on reset assertion mid-operation, and SHALL resume from the first edge after release.

Configuration
REQ-029 SHALL honour macro RS_OLDEST_FIRST_EN.
REQ-030 SHALL, with RS_OLDEST_FIRST_EN defined, select the eligible entry with the largest age (ties: lowest index); without it, select the lowest-index eligible entry, with no age counters synthesised.

Structure
REQ-031 SHALL take TYPE_BIT, ROB_INDEX_BIT and opcode encodings from the shared constants header; RS_SIZE and AGE_BIT defaults are defined there too.
REQ-032 SHALL place dispatch selection in a sub-module rs_select (eligible vector plus ages in, one-hot grant and valid out).

Verification
REQ-033 Bench: issue ADD, vj=5, vk=7, both ready, rob 3 -> alu_req=1 after 2 edges, type ADD, r1=5, r2=7, rob 3; entry freed.
REQ-034 Bench: issue with qj=4 not ready; cdb_alu rob 4, value 0x10, two cycles later -> dispatch the cycle after wakeup with r1=0x10.
REQ-035 Bench: issue with qk=6 while cdb_lsb rob 6, value 9, in the same cycle -> k captured, dispatch with r2=9, no hang.
REQ-036 Bench: fill 8 entries, all waiting -> full=1; 9th issue dropped; one wakeup plus dispatch -> full=0 next cycle.
REQ-037 Bench: with RS_OLDEST_FIRST_EN, issue entries A then B (B in lower index after free), wake both together -> A dispatched first; without the macro, the lower index is dispatched first.
REQ-038 Bench: 3 busy entries, clear_in with rdy_in=1 -> all freed, alu_req=0 next cycle; rdy_in=0 for 3 cycles mid-run -> outputs frozen, no CDB capture.
